// File: rtl/memory_cycle.sv
// M-stage data-memory access unit and M/W pipeline register. Issues one bus
// request per legal load/store. It stalls the pipeline until dmem_ack arrives or the wait times out.
// state  | meaning
// S_IDLE | no access outstanding; a legal access is presented to the bus this cycle
// S_WAIT | access issued but not acked; bus held, pipeline frozen, timeout counting
module memory_cycle #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [2:0]  ResultSrcM,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] luAuiPCM,
    input  logic [31:0] InstrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [2:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] luAuiPCW,
    output logic [31:0] InstrW,
    output logic [1:0]  ExcW
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               reg_write_q, reg_write_d;
    logic [2:0]         result_src_q, result_src_d;
    logic [4:0]         rd_q, rd_d;
    logic [31:0]        alu_result_q, alu_result_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [31:0]        pc_plus4_q, pc_plus4_d;
    logic [31:0]        lu_aui_pc_q, lu_aui_pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [1:0]         exc_q, exc_d;

    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        is_store, is_load, access;
    logic        f3_legal, misaligned, fault, go;
    logic [1:0]  fault_code;
    logic        req, stall, complete, timeout;
    logic        bus_req;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    assign funct3   = InstrM[14:12];
    assign addr_lo  = ALUResultM[1:0];
    assign is_store = MemWriteM;
    assign is_load  = (ResultSrcM == 3'b001) && !MemWriteM;
    assign access   = is_store || is_load;

    always_comb begin
        f3_legal = 1'b0;
        if (is_store) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default:                f3_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end
    end

    assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    assign fault      = access && (!f3_legal || misaligned);
    assign fault_code = !f3_legal ? 2'b10 : 2'b01;
    assign go         = access && !fault;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Async reset clears state immediately, but M inputs may still look like an access.
    assign bus_req = req && !rst;
    assign StallM  = stall && !rst;

    always_comb begin
        dmem_req   = bus_req;
        dmem_we    = bus_req && is_store;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = 4'b0000;
        if (bus_req) begin
            dmem_addr = {ALUResultM[31:2], 2'b00};
            dmem_be   = 4'b1111;
            if (is_store) begin
                case (funct3[1:0])
                    2'b00: begin
                        dmem_be    = 4'b0001 << addr_lo;
                        dmem_wdata = {4{WriteDataM[7:0]}};
                    end
                    2'b01: begin
                        dmem_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                        dmem_wdata = {2{WriteDataM[15:0]}};
                    end
                    default: dmem_wdata = WriteDataM;
                endcase
            end
        end
    end

    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        reg_write_d  = 1'b0;
        exc_d        = 2'b00;
        result_src_d = result_src_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        pc_plus4_d   = pc_plus4_q;
        lu_aui_pc_d  = lu_aui_pc_q;
        instr_d      = instr_q;
        if (!stall) begin
            result_src_d = ResultSrcM;
            rd_d         = RdM;
            alu_result_d = ALUResultM;
            pc_plus4_d   = PCPlus4M;
            lu_aui_pc_d  = luAuiPCM;
            instr_d      = InstrM;
            if (fault) begin
                exc_d = fault_code;
            end else if (timeout) begin
                exc_d = 2'b11;
            end else begin
                reg_write_d = RegWriteM;
            end
            if (complete && is_load) begin
                read_data_d = load_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            rd_q         <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus4_q   <= '0;
            lu_aui_pc_q  <= '0;
            instr_q      <= '0;
            exc_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            pc_plus4_q   <= pc_plus4_d;
            lu_aui_pc_q  <= lu_aui_pc_d;
            instr_q      <= instr_d;
            exc_q        <= exc_d;
        end
    end

    assign RegWriteW  = reg_write_q;
    assign ResultSrcW = result_src_q;
    assign RdW        = rd_q;
    assign ALUResultW = alu_result_q;
    assign ReadDataW  = read_data_q;
    assign PCPlus4W   = pc_plus4_q;
    assign luAuiPCW   = lu_aui_pc_q;
    assign InstrW     = instr_q;
    assign ExcW       = exc_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: directed scenarios then randomized loads/stores/nops,
// checked against a byte-arithmetic model of the access rules.
module tb_memory_cycle;
    localparam int MEM_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM;
    logic [2:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, luAuiPCM, InstrM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        StallM;
    logic        RegWriteW;
    logic [2:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, luAuiPCW, InstrW;
    logic [1:0]  ExcW;

    int checks = 0;
    int failures = 0;

    // Expected W-register contents.
    logic        m_rw;
    logic [2:0]  m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdata, m_pc4, m_lui, m_instr;
    logic [1:0]  m_exc;

    logic [3:0]  obs_be;
    logic [31:0] obs_wd, obs_addr;
    logic        obs_we;
    logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    memory_cycle #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .luAuiPCM(luAuiPCM), .InstrM(InstrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .luAuiPCW(luAuiPCW), .InstrW(InstrW), .ExcW(ExcW)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        int          sz;
        logic [31:0] v, mask;
        sz = 1 << f3[1:0];
        if (sz >= 4) return w;
        v    = w >> (8 * (a % 4));
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic drive_m(input logic rw, input logic mw, input logic [2:0] rs,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] ins);
        RegWriteM  = rw;
        MemWriteM  = mw;
        ResultSrcM = rs;
        RdM        = 5'($urandom);
        ALUResultM = alu;
        WriteDataM = wd;
        PCPlus4M   = $urandom;
        luAuiPCM   = $urandom;
        InstrM     = ins;
    endtask

    task automatic capture_m();
        m_rs    = ResultSrcM;
        m_rd    = RdM;
        m_alu   = ALUResultM;
        m_pc4   = PCPlus4M;
        m_lui   = luAuiPCM;
        m_instr = InstrM;
    endtask

    task automatic check_w(input string tag);
        chk({tag, "_RegWriteW"},  32'(RegWriteW),  32'(m_rw));
        chk({tag, "_ExcW"},       32'(ExcW),       32'(m_exc));
        chk({tag, "_ResultSrcW"}, 32'(ResultSrcW), 32'(m_rs));
        chk({tag, "_RdW"},        32'(RdW),        32'(m_rd));
        chk({tag, "_ALUResultW"}, ALUResultW,      m_alu);
        chk({tag, "_ReadDataW"},  ReadDataW,       m_rdata);
        chk({tag, "_PCPlus4W"},   PCPlus4W,        m_pc4);
        chk({tag, "_luAuiPCW"},   luAuiPCW,        m_lui);
        chk({tag, "_InstrW"},     InstrW,          m_instr);
    endtask

    task automatic run_nop();
        logic [2:0] rs;
        rs = 3'($urandom_range(0, 7));
        if (rs == 3'b001) rs = 3'b010;
        drive_m(1'($urandom), 1'b0, rs, $urandom, $urandom, $urandom);
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
        #1;
        chk("nop_req", 32'(dmem_req), 32'd0);
        chk("nop_stall", 32'(StallM), 32'd0);
        @(posedge clk);
        @(negedge clk);
        capture_m();
        m_rw  = RegWriteM;
        m_exc = 2'b00;
        check_w("nop");
    endtask

    // delay = cycle index (0 = same cycle) in which ack is driven; -1 = never.
    task automatic run_txn(input string tag, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rword, input int delay, input logic rw,
                           output int stalls);
        int          sz;
        bit          legal, fault, fin, acked, tmo;
        logic [1:0]  code;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, ins;
        logic [2:0]  rs;
        sz     = 1 << f3[1:0];
        legal  = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        code   = !legal ? 2'b10 : ((addr % 32'(sz)) != 0) ? 2'b01 : 2'b00;
        fault  = (code != 2'b00);
        exp_be = st ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'hF;
        exp_wd = '0;
        if (st) for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
        ins = $urandom;
        ins[14:12] = f3;
        rs = st ? 3'($urandom_range(0, 7)) : 3'b001;
        drive_m(rw, st, rs, addr, wd, ins);
        stalls = 0;
        tmo    = 1'b0;
        for (int c = 0; c <= MEM_TIMEOUT; c++) begin
            acked      = !fault && (c == delay);
            dmem_ack   = fault ? 1'($urandom) : acked;
            dmem_rdata = acked ? rword : $urandom;
            fin        = fault || acked || (c == MEM_TIMEOUT);
            #1;
            chk({tag, "_req"}, 32'(dmem_req), 32'(!fault));
            chk({tag, "_stall"}, 32'(StallM), 32'(!fin));
            if (c == 0) begin
                obs_be = dmem_be; obs_wd = dmem_wdata; obs_addr = dmem_addr; obs_we = dmem_we;
            end
            if (!fault) begin
                chk({tag, "_addr"}, dmem_addr, addr - (addr % 4));
                chk({tag, "_we"}, 32'(dmem_we), 32'(st));
                chk({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
                if (st) chk({tag, "_wdata"}, dmem_wdata, exp_wd);
            end
            @(posedge clk);
            @(negedge clk);
            if (!fin) begin
                stalls++;
                chk({tag, "_bub_rw"}, 32'(RegWriteW), 32'd0);
                chk({tag, "_bub_exc"}, 32'(ExcW), 32'd0);
                chk({tag, "_bub_rd"}, 32'(RdW), 32'(m_rd));
                chk({tag, "_bub_instr"}, InstrW, m_instr);
                chk({tag, "_bub_rdata"}, ReadDataW, m_rdata);
            end else begin
                tmo   = !fault && !acked;
                m_exc = fault ? code : (tmo ? 2'b11 : 2'b00);
                m_rw  = rw && (m_exc == 2'b00);
                if (acked && !st) m_rdata = ld_val(f3, addr, rword);
                capture_m();
                check_w(tag);
                break;
            end
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        int          stalls;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          kind, delay;

        rst = 1'b1;
        drive_m(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h0000_2003);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_5678;
        #12;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        m_rw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_rdata = 0;
        m_pc4 = 0; m_lui = 0; m_instr = 0; m_exc = 0;
        check_w("rst");
        @(negedge clk);
        rst = 1'b0;

        run_txn("lw_same", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, stalls);
        chk("lw_same_stalls", 32'(stalls), 32'd0);
        chk("lw_same_rdata", ReadDataW, 32'hDEAD_BEEF);
        chk("lw_same_rw", 32'(RegWriteW), 32'd1);

        run_txn("lb_wait", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 3, 1'b1, stalls);
        chk("lb_wait_stalls", 32'(stalls), 32'd3);
        chk("lb_wait_rdata", ReadDataW, 32'hFFFF_FF80);

        run_txn("sh", 1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'h0, 0, 1'b0, stalls);
        chk("sh_we", 32'(obs_we), 32'd1);
        chk("sh_be", 32'(obs_be), 32'b1100);
        chk("sh_wdata", obs_wd, 32'h1234_1234);
        chk("sh_addr", obs_addr, 32'h200);

        run_txn("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b1, stalls);
        chk("lw_mis_rw", 32'(RegWriteW), 32'd0);
        chk("lw_mis_exc", 32'(ExcW), 32'd1);

        run_txn("lhu_tmo", 1'b0, 3'b101, 32'h204, 32'h0, 32'h0, -1, 1'b1, stalls);
        chk("lhu_tmo_stalls", 32'(stalls), 32'(MEM_TIMEOUT));
        chk("lhu_tmo_exc", 32'(ExcW), 32'd3);
        chk("lhu_tmo_rw", 32'(RegWriteW), 32'd0);
        run_txn("after_tmo", 1'b0, 3'b010, 32'h208, 32'h0, 32'hCAFE_F00D, 0, 1'b1, stalls);
        chk("after_tmo_stalls", 32'(stalls), 32'd0);

        run_txn("ack_last", 1'b0, 3'b001, 32'h20E, 32'h0, 32'h8001_7FFF, MEM_TIMEOUT, 1'b1, stalls);
        chk("ack_last_stalls", 32'(stalls), 32'(MEM_TIMEOUT));
        chk("ack_last_exc", 32'(ExcW), 32'd0);
        chk("ack_last_rdata", ReadDataW, 32'hFFFF_8001);
        run_txn("ack_m1", 1'b1, 3'b000, 32'h301, 32'h0000_00A5, 32'h0, MEM_TIMEOUT - 1, 1'b0, stalls);
        chk("ack_m1_stalls", 32'(stalls), 32'(MEM_TIMEOUT - 1));
        run_txn("lb_ill", 1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 0, 1'b1, stalls);
        chk("lb_ill_exc", 32'(ExcW), 32'd2);
        run_txn("st_ill", 1'b1, 3'b100, 32'h400, 32'h0, 32'h0, 0, 1'b1, stalls);
        chk("st_ill_exc", 32'(ExcW), 32'd2);

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                run_nop();
            end else begin
                f3 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0)
                    f3 = (kind == 2) ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
                addr = $urandom;
                if ($urandom_range(0, 1) != 0) addr[1:0] = 2'b00;
                delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
                run_txn("rnd", kind == 2, f3, addr, $urandom, $urandom, delay, 1'($urandom), stalls);
            end
        end

        drive_m(1'b1, 1'b0, 3'b001, 32'h300, 32'h0, 32'h0000_2003);
        dmem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rstw_pre_stall", 32'(StallM), 32'd1);
        rst = 1'b1;
        RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RdM = 0; ALUResultM = 0;
        WriteDataM = 0; PCPlus4M = 0; luAuiPCM = 0; InstrM = 0;
        #1;
        chk("rstw_req", 32'(dmem_req), 32'd0);
        chk("rstw_stall", 32'(StallM), 32'd0);
        m_rw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_rdata = 0;
        m_pc4 = 0; m_lui = 0; m_instr = 0; m_exc = 0;
        check_w("rstw");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        #1;
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_stall", 32'(StallM), 32'd0);
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        check_w("late_ack");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
